// File: rtl/conversor_bcd_rolhas.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the cork counter.
// Start/done handshake; results saturate to all nines when the count does not fit.
module conversor_bcd_rolhas #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [AW-1:0]     acc_q, acc_d, acc_adj;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     bcd_q, bcd_d;
  logic              ovr_q, ovr_d;

  // Per-digit correction: digits of 5 or more get +3 so the next shift carries into the next decade.
  function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] >= 4'd5) r[4*k +: 4] = a[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] saturate(input logic [AW-1:0] a, input logic ovf);
    return ovf ? {DIGITS{4'h9}} : a;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovr_d   = ovr_q;
    acc_adj = add3(acc_q);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shreg_d = bin_in;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // A bit leaving the top digit means the value no longer fits in DIGITS decades.
        acc_d   = {acc_adj[AW-2:0], shreg_q[WIDTH-1]};
        shreg_d = shreg_q << 1;
        ovf_d   = ovf_q | acc_adj[AW-1];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          bcd_d   = saturate(acc_d, ovf_d);
          ovr_d   = ovf_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_q;
  assign overflow = ovr_q;

endmodule

// File: tb/tb_conversor_bcd_rolhas.sv
// Directed bench for conversor_bcd_rolhas: four parameterisations driven from a shared clock/reset.
module tb_conversor_bcd_rolhas;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [6:0]  bin7;
  logic        start_e;
  logic [9:0]  bin_e;

  logic ready_a, busy_a, done_a, ovf_a; logic [11:0] bcd_a;
  logic ready_b, busy_b, done_b, ovf_b; logic [7:0]  bcd_b;
  logic ready_c, busy_c, done_c, ovf_c; logic [3:0]  bcd_c;
  logic ready_e, busy_e, done_e, ovf_e; logic [15:0] bcd_e;

  int n_chk  = 0;
  int n_fail = 0;
  int lat, nbusy, nd, cyc, t1, t2;
  logic [11:0] ra_bcd; logic ra_ovf;
  logic [7:0]  rb_bcd; logic rb_ovf;
  logic [3:0]  rc_bcd; logic rc_ovf;
  logic [15:0] re_bcd; logic re_ovf;

  always #5 clk = ~clk;

  conversor_bcd_rolhas #(.WIDTH(7), .DIGITS(3)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin7),
    .ready(ready_a), .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a));
  conversor_bcd_rolhas #(.WIDTH(7), .DIGITS(2)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin7),
    .ready(ready_b), .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b));
  conversor_bcd_rolhas #(.WIDTH(7), .DIGITS(1)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin7),
    .ready(ready_c), .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c));
  conversor_bcd_rolhas #(.WIDTH(10), .DIGITS(4)) u_e (
    .clk(clk), .reset_n(reset_n), .start(start_e), .bin_in(bin_e),
    .ready(ready_e), .busy(busy_e), .done(done_e), .bcd_out(bcd_e), .overflow(ovf_e));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bcd_model(input int v);
    return 32'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Pulse start for the three WIDTH=7 instances and capture the done-cycle outputs.
  task automatic conv7(input logic [6:0] v);
    bin7 = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; nbusy = 0;
    while (!done_a && lat < 30) begin
      if (busy_a) nbusy++;
      @(posedge clk); #1; lat++;
    end
    ra_bcd = bcd_a; ra_ovf = ovf_a;
    rb_bcd = bcd_b; rb_ovf = ovf_b;
    rc_bcd = bcd_c; rc_ovf = ovf_c;
    @(posedge clk); #1;
  endtask

  task automatic conv10(input logic [9:0] v);
    bin_e = v; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    lat = 0;
    while (!done_e && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    re_bcd = bcd_e; re_ovf = ovf_e;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; start = 1'b0; start_e = 1'b0; bin7 = '0; bin_e = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready_a", ready_a, 1); chk("rst_busy_a", busy_a, 0); chk("rst_done_a", done_a, 0);
    chk("rst_bcd_a", bcd_a, 0);     chk("rst_ovf_a", ovf_a, 0);
    chk("rst_ready_b", ready_b, 1); chk("rst_busy_b", busy_b, 0); chk("rst_done_b", done_b, 0);
    chk("rst_bcd_b", bcd_b, 0);     chk("rst_ovf_b", ovf_b, 0);
    chk("rst_ready_c", ready_c, 1); chk("rst_busy_c", busy_c, 0); chk("rst_done_c", done_c, 0);
    chk("rst_bcd_c", bcd_c, 0);     chk("rst_ovf_c", ovf_c, 0);
    chk("rst_ready_e", ready_e, 1); chk("rst_busy_e", busy_e, 0); chk("rst_done_e", done_e, 0);
    chk("rst_bcd_e", bcd_e, 0);     chk("rst_ovf_e", ovf_e, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // 127 on all WIDTH=7 instances
    conv7(7'd127);
    chk("c127_lat", lat, 7);   chk("c127_busy", nbusy, 7);
    chk("c127_a_bcd", ra_bcd, 12'h127); chk("c127_a_ovf", ra_ovf, 0);
    chk("c127_b_bcd", rb_bcd, 8'h99);   chk("c127_b_ovf", rb_ovf, 1);
    chk("c127_c_bcd", rc_bcd, 4'h9);    chk("c127_c_ovf", rc_ovf, 1);
    chk("idle_ready", ready_a, 1);      chk("idle_hold", bcd_a, 12'h127);

    conv7(7'd99);
    chk("c99_b_bcd", rb_bcd, 8'h99);  chk("c99_b_ovf", rb_ovf, 0);
    chk("c99_a_bcd", ra_bcd, 12'h099);
    conv7(7'd100);
    chk("c100_b_bcd", rb_bcd, 8'h99); chk("c100_b_ovf", rb_ovf, 1);
    chk("c100_a_bcd", ra_bcd, 12'h100); chk("c100_a_ovf", ra_ovf, 0);

    // Full sweep of the 7-bit input range
    for (int v = 0; v < 128; v++) begin
      conv7(v[6:0]);
      chk("sw_lat", lat, 7);
      chk("sw_c_bcd", rc_bcd, (v <= 9) ? v : 9);
      chk("sw_c_ovf", rc_ovf, (v > 9) ? 1 : 0);
      chk("sw_b_bcd", rb_bcd, (v > 99) ? 32'h99 : bcd_model(v));
      chk("sw_b_ovf", rb_ovf, (v > 99) ? 1 : 0);
      chk("sw_a_bcd", ra_bcd, bcd_model(v));
      chk("sw_a_ovf", ra_ovf, 0);
    end

    // Back-to-back with start held high; bin_in changes mid-conversion
    bin7 = 7'd45; start = 1'b1;
    @(posedge clk); #1;
    bin7 = 7'd86;
    cyc = 0; t1 = -1; t2 = -1; nd = 0;
    while (cyc < 40 && t2 < 0) begin
      if (done_a) begin
        nd++;
        if (t1 < 0) begin
          t1 = cyc;
          chk("b2b_first", bcd_a, 12'h045);
        end else begin
          t2 = cyc;
          chk("b2b_second", bcd_a, 12'h086);
        end
      end
      if (t1 >= 0 && cyc == t1 + 3) chk("b2b_hold", bcd_a, 12'h045);
      if (t2 < 0) begin
        @(posedge clk); #1; cyc++;
      end
    end
    start = 1'b0;
    chk("b2b_lat", t1, 7);
    chk("b2b_spacing", t2 - t1, 8);
    chk("b2b_pulses", nd, 2);
    @(posedge clk); #1;
    chk("b2b_done_low", done_a, 0); chk("b2b_idle", ready_a, 1);

    // Asynchronous reset in the middle of a conversion of 77
    bin7 = 7'd77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_before", busy_a, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_busy", busy_a, 0); chk("mid_ready", ready_a, 1); chk("mid_done", done_a, 0);
    chk("mid_bcd_a", bcd_a, 0); chk("mid_ovf_c", ovf_c, 0); chk("mid_bcd_b", bcd_b, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_a) nd++;
    end
    chk("mid_no_done", nd, 0);
    conv7(7'd77);
    chk("post_lat", lat, 7);
    chk("post_a_bcd", ra_bcd, 12'h077); chk("post_a_ovf", ra_ovf, 0);
    chk("post_b_bcd", rb_bcd, 8'h77);   chk("post_c_ovf", rc_ovf, 1);

    // WIDTH=10, DIGITS=4
    conv10(10'd1023);
    chk("e1023_lat", lat, 10);
    chk("e1023_bcd", re_bcd, 16'h1023); chk("e1023_ovf", re_ovf, 0);
    conv10(10'd0);
    chk("e0_lat", lat, 10);
    chk("e0_bcd", re_bcd, 16'h0000);    chk("e0_ovf", re_ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
